// File: rtl/irq_encoder8x3_if.sv
// Request/grant bundle between peripheral request lines, the encoder and its consumer.
// Latency: none (wires only).
// Backpressure: consumer holds a grant by keeping ack low while valid is high.
interface irq_encoder8x3_if;
  logic       enable;
  logic [7:0] req;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
  logic       overflow;

  // Consumer / stimulus side.
  modport master (
    output enable,
    output req,
    output ack,
    input  code,
    input  valid,
    input  pending,
    input  overflow
  );

  // Encoder side.
  modport slave (
    input  enable,
    input  req,
    input  ack,
    output code,
    output valid,
    output pending,
    output overflow
  );
endinterface

// File: rtl/irq_encoder8x3.sv
// Registered 8-to-3 priority encoder: captures req rising edges, grants one code at a time.
// Latency: req edge to valid is 2 cycles; enable rise to valid is 1 cycle when events wait.
// Backpressure: a grant is held (code frozen, valid high) until ack; events queue in pending.
module irq_encoder8x3 #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  irq_encoder8x3_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] req_q;
  logic [7:0] pending_q, pending_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       overflow_q, overflow_d;

  logic [7:0] edge_w;
  logic [7:0] clr;
  logic [7:0] lost;

  // Winner among pending lines: highest index when PRIORITY_HIGH, else lowest.
  function automatic logic [2:0] pick(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) r = i[2:0];
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) r = i[2:0];
      end
    end
    return r;
  endfunction

  // Event capture and pending bookkeeping; a new edge beats a same-cycle clear.
  always_comb begin
    edge_w     = bus.req & ~req_q;
    clr        = (valid_q && bus.ack) ? (8'b1 << code_q) : 8'h00;
    lost       = edge_w & pending_q & ~clr;
    pending_d  = (pending_q & ~clr) | edge_w;
    overflow_d = overflow_q | (|lost);
  end

  // Grant FSM: arbitrate on registered pending in IDLE, hold the grant until ack.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.enable && (pending_q != 8'h00)) begin
          code_d  = pick(pending_q);
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bus.ack) begin
          code_d  = 3'd0;
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        code_d  = 3'd0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any grant and drops all captured events.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 8'h00;
      pending_q  <= 8'h00;
      code_q     <= 3'd0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= bus.req;
      pending_q  <= pending_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.code     = code_q;
  assign bus.valid    = valid_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_irq_encoder8x3.sv
// Bench for irq_encoder8x3: directed vector table, hand sequence for low priority, random vs model.
// Latency: checks taken on the falling edge after each rising edge.
// Backpressure: ack driven directly per instance.
module tb_irq_encoder8x3;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] req;
  logic       ack_hi;
  logic       ack_lo;

  int checks;
  int failures;

  irq_encoder8x3_if hi_if();
  irq_encoder8x3_if lo_if();

  assign hi_if.enable = enable;
  assign hi_if.req    = req;
  assign hi_if.ack    = ack_hi;
  assign lo_if.enable = enable;
  assign lo_if.req    = req;
  assign lo_if.ack    = ack_lo;

  irq_encoder8x3 #(.PRIORITY_HIGH(1'b1)) dut_hi (.clk(clk), .rst(rst), .bus(hi_if));
  irq_encoder8x3 #(.PRIORITY_HIGH(1'b0)) dut_lo (.clk(clk), .rst(rst), .bus(lo_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, index 0 = high priority instance, 1 = low priority instance.
  bit [7:0] m_reqq [2];
  bit [7:0] m_pend [2];
  int       m_code [2];
  bit       m_valid[2];
  bit       m_ovf  [2];

  task automatic model_step(input int p, input bit a);
    int  pend_idx[$];
    int  cleared;
    bit [7:0] old_pend;
    if (rst) begin
      m_reqq[p] = 0; m_pend[p] = 0; m_code[p] = 0; m_valid[p] = 0; m_ovf[p] = 0;
      return;
    end
    old_pend = m_pend[p];
    cleared  = (m_valid[p] && a) ? m_code[p] : -1;
    for (int i = 0; i < 8; i++) begin
      bit rose;
      rose = req[i] && !m_reqq[p][i];
      if (rose && old_pend[i] && i != cleared) m_ovf[p] = 1;
      if (i == cleared) m_pend[p][i] = 0;
      if (rose) m_pend[p][i] = 1;
      if (old_pend[i]) pend_idx.push_back(i);
    end
    if (!m_valid[p]) begin
      if (enable && pend_idx.size() > 0) begin
        m_code[p]  = (p == 0) ? pend_idx[pend_idx.size()-1] : pend_idx[0];
        m_valid[p] = 1;
      end
    end else if (a) begin
      m_code[p]  = 0;
      m_valid[p] = 0;
    end
    m_reqq[p] = req;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: model advances with the DUT, outputs settle before the falling edge.
  task automatic step();
    @(posedge clk);
    model_step(0, ack_hi);
    model_step(1, ack_lo);
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " hi code"},    32'(hi_if.code),     32'(m_code[0]));
    chk({tag, " hi valid"},   32'(hi_if.valid),    32'(m_valid[0]));
    chk({tag, " hi pending"}, 32'(hi_if.pending),  32'(m_pend[0]));
    chk({tag, " hi ovf"},     32'(hi_if.overflow), 32'(m_ovf[0]));
    chk({tag, " lo code"},    32'(lo_if.code),     32'(m_code[1]));
    chk({tag, " lo valid"},   32'(lo_if.valid),    32'(m_valid[1]));
    chk({tag, " lo pending"}, 32'(lo_if.pending),  32'(m_pend[1]));
    chk({tag, " lo ovf"},     32'(lo_if.overflow), 32'(m_ovf[1]));
  endtask

  typedef struct {
    bit       rst;
    bit       en;
    bit [7:0] req;
    bit       ack;
    bit [2:0] code;
    bit       valid;
    bit [7:0] pend;
    bit       ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit e, input bit [7:0] q, input bit a,
                     input bit [2:0] c, input bit v, input bit [7:0] pd, input bit o);
    vec_t t;
    t.rst = r; t.en = e; t.req = q; t.ack = a;
    t.code = c; t.valid = v; t.pend = pd; t.ovf = o;
    tbl.push_back(t);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; enable = 1'b1; req = 8'h00; ack_hi = 1'b0; ack_lo = 1'b0;

    // rst en req ack | code valid pending ovf  (expected after the edge, high-priority instance)
    add(1,1,8'hFF,0, 0,0,8'h00,0);   // reset with requests held
    add(1,1,8'hFF,0, 0,0,8'h00,0);
    add(0,1,8'hFF,0, 0,0,8'hFF,0);   // held lines register right after release
    add(1,1,8'h00,0, 0,0,8'h00,0);
    add(0,1,8'h00,0, 0,0,8'h00,0);
    add(0,1,8'h20,0, 0,0,8'h20,0);   // single event on line 5
    add(0,1,8'h00,0, 5,1,8'h20,0);
    add(0,1,8'h00,0, 5,1,8'h20,0);   // held without ack
    add(0,1,8'h00,0, 5,1,8'h20,0);
    add(0,1,8'h00,0, 5,1,8'h20,0);
    add(0,1,8'h00,1, 0,0,8'h00,0);
    add(0,1,8'h00,0, 0,0,8'h00,0);
    add(0,1,8'h22,0, 0,0,8'h22,0);   // simultaneous 1 and 5
    add(0,1,8'h00,0, 5,1,8'h22,0);
    add(0,1,8'h00,1, 0,0,8'h02,0);
    add(0,1,8'h00,0, 1,1,8'h02,0);
    add(0,1,8'h80,0, 1,1,8'h82,0);   // line 7 arrives, no preemption
    add(0,1,8'h00,0, 1,1,8'h82,0);
    add(0,1,8'h00,1, 0,0,8'h80,0);
    add(0,1,8'h00,0, 7,1,8'h80,0);
    add(0,1,8'h00,1, 0,0,8'h00,0);
    add(0,0,8'h04,0, 0,0,8'h04,0);   // enable low gates grants
    add(0,0,8'h00,0, 0,0,8'h04,0);
    add(0,0,8'h00,1, 0,0,8'h04,0);   // ack while idle ignored
    add(0,0,8'h00,0, 0,0,8'h04,0);
    add(0,1,8'h00,0, 2,1,8'h04,0);
    add(0,1,8'h00,1, 0,0,8'h00,0);
    add(0,1,8'h08,0, 0,0,8'h08,0);   // edge and clear on same line: set wins
    add(0,1,8'h00,0, 3,1,8'h08,0);
    add(0,1,8'h08,1, 0,0,8'h08,0);
    add(0,1,8'h00,0, 3,1,8'h08,0);
    add(0,1,8'h00,1, 0,0,8'h00,0);
    add(0,1,8'h08,0, 0,0,8'h08,0);   // double event on line 3 overflows
    add(0,1,8'h00,0, 3,1,8'h08,0);
    add(0,1,8'h08,0, 3,1,8'h08,1);
    add(0,1,8'h00,0, 3,1,8'h08,1);
    add(0,1,8'h00,1, 0,0,8'h00,1);
    add(0,1,8'h00,0, 0,0,8'h00,1);   // only one grant for line 3
    add(0,1,8'h40,0, 0,0,8'h40,1);
    add(0,1,8'h00,0, 6,1,8'h40,1);
    add(1,1,8'h00,0, 0,0,8'h00,0);   // reset during grant
    add(0,1,8'h00,0, 0,0,8'h00,0);
    add(0,1,8'h00,0, 0,0,8'h00,0);
    add(0,1,8'h00,0, 0,0,8'h00,0);

    foreach (tbl[k]) begin
      string tag;
      rst = tbl[k].rst; enable = tbl[k].en; req = tbl[k].req;
      ack_hi = tbl[k].ack; ack_lo = tbl[k].ack;
      step();
      tag = $sformatf("vec%0d", k);
      chk({tag, " code"},    32'(hi_if.code),     32'(tbl[k].code));
      chk({tag, " valid"},   32'(hi_if.valid),    32'(tbl[k].valid));
      chk({tag, " pending"}, 32'(hi_if.pending),  32'(tbl[k].pend));
      chk({tag, " ovf"},     32'(hi_if.overflow), 32'(tbl[k].ovf));
      chk_model(tag);
    end

    // Low-priority grant order for simultaneous lines 1 and 5.
    ack_hi = 1'b0; ack_lo = 1'b0; enable = 1'b1;
    rst = 1'b1; req = 8'h00; step();
    rst = 1'b0; req = 8'h22; step();
    req = 8'h00; step();
    chk("lo first valid", 32'(lo_if.valid), 32'd1);
    chk("lo first code",  32'(lo_if.code),  32'd1);
    ack_lo = 1'b1; step();
    chk("lo ack valid",   32'(lo_if.valid),   32'd0);
    chk("lo ack pending", 32'(lo_if.pending), 32'h20);
    ack_lo = 1'b0; step();
    chk("lo second code",  32'(lo_if.code),  32'd5);
    chk("lo second valid", 32'(lo_if.valid), 32'd1);
    chk_model("lo_seq");

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      req    = req ^ 8'($urandom & $urandom & $urandom);
      enable = ($urandom_range(0, 9) != 0);
      ack_hi = ($urandom_range(0, 2) == 0);
      ack_lo = ($urandom_range(0, 2) == 0);
      rst    = ($urandom_range(0, 199) == 0);
      step();
      chk_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
